// File: rtl/eoc_monitor_if.sv
// Control/status bundle between a test harness (or FPGA status logic) and eoc_monitor.
// The harness side uses the master modport, the monitor the slave modport.
interface eoc_monitor_if #(
   parameter int NUM_CH    = 1,
   parameter int TIMEOUT_W = 32
);
   logic                 start_i;
   logic                 clear_i;
   logic [NUM_CH-1:0]    done_i;
   logic [NUM_CH-1:0]    pass_i;
   logic [TIMEOUT_W-1:0] timeout_cycles_i;
   logic                 busy_o;
   logic                 eoc_o;
   logic                 eoc_pulse_o;
   logic                 timeout_o;
   logic [7:0]           exit_code_o;
   logic [NUM_CH-1:0]    done_mask_o;
   logic [NUM_CH-1:0]    pass_mask_o;
   logic [TIMEOUT_W-1:0] cycle_count_o;

   modport master (
      output start_i, clear_i, done_i, pass_i, timeout_cycles_i,
      input  busy_o, eoc_o, eoc_pulse_o, timeout_o, exit_code_o,
             done_mask_o, pass_mask_o, cycle_count_o
   );

   modport slave (
      input  start_i, clear_i, done_i, pass_i, timeout_cycles_i,
      output busy_o, eoc_o, eoc_pulse_o, timeout_o, exit_code_o,
             done_mask_o, pass_mask_o, cycle_count_o
   );
endinterface

// File: rtl/eoc_monitor.sv
// End-of-computation monitor: filters per-channel done/pass GPIO flags, runs a cycle
// watchdog and reports a PULPino-style exit code (0 pass, 1 fail, 8'hFF error/not finished).
module eoc_monitor #(
   parameter int NUM_CH        = 1,
   parameter int STABLE_CYCLES = 4,
   parameter int TIMEOUT_W     = 32
) (
   input  logic         clk,
   input  logic         rst,
   eoc_monitor_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE, TIMEOUT} state_t;

   localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

   state_t               state_reg;
   logic                 start_reg;
   logic                 start_prev_reg;
   logic [NUM_CH-1:0]    done_meta_reg;
   logic [NUM_CH-1:0]    done_sync_reg;
   logic [NUM_CH-1:0]    pass_meta_reg;
   logic [NUM_CH-1:0]    pass_sync_reg;
   logic [TIMEOUT_W-1:0] count_reg;
   logic                 busy_reg;
   logic                 eoc_reg;
   logic                 eoc_pulse_reg;
   logic                 timeout_reg;
   logic [7:0]           exit_code_reg;

   logic [NUM_CH-1:0]    done_mask;
   logic [NUM_CH-1:0]    pass_mask;
   logic                 start_edge;
   logic                 all_done;
   logic                 limit_hit;
   logic                 arm;
   logic                 go_done;
   logic                 go_timeout;
   logic                 run_hold;

   assign start_edge = start_reg & ~start_prev_reg;
   assign all_done   = &done_mask;
   assign limit_hit  = (bus.timeout_cycles_i != '0) && (count_reg >= bus.timeout_cycles_i);

   // Transition qualifiers in priority order: clear > start edge > completion > timeout.
   assign arm        = !bus.clear_i && start_edge && (state_reg != RUN);
   assign go_done    = !bus.clear_i && (state_reg == RUN) && all_done;
   assign go_timeout = !bus.clear_i && (state_reg == RUN) && !all_done && limit_hit;
   assign run_hold   = !bus.clear_i && (state_reg == RUN) && !all_done && !limit_hit;

   // start_reg/start_prev_reg reset high so a start_i already high at release is not an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_reg      <= 1'b1;
         start_prev_reg <= 1'b1;
         done_meta_reg  <= '0;
         done_sync_reg  <= '0;
         pass_meta_reg  <= '0;
         pass_sync_reg  <= '0;
      end else begin
         start_reg      <= bus.start_i;
         start_prev_reg <= start_reg;
         done_meta_reg  <= bus.done_i;
         done_sync_reg  <= done_meta_reg;
         pass_meta_reg  <= bus.pass_i;
         pass_sync_reg  <= pass_meta_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [7:0] filt_reg;
         logic       done_acc_reg;
         logic       pass_acc_reg;

         // Filter counts consecutive synced highs; the accepted bit then freezes until re-arm.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               filt_reg     <= '0;
               done_acc_reg <= 1'b0;
               pass_acc_reg <= 1'b0;
            end else if (bus.clear_i || arm) begin
               filt_reg     <= '0;
               done_acc_reg <= 1'b0;
               pass_acc_reg <= 1'b0;
            end else if (run_hold && !done_acc_reg && done_sync_reg[gi]) begin
               if (filt_reg == STABLE_LAST) begin
                  filt_reg     <= '0;
                  done_acc_reg <= 1'b1;
                  pass_acc_reg <= pass_sync_reg[gi];
               end else begin
                  filt_reg <= filt_reg + 8'd1;
               end
            end else begin
               filt_reg <= '0;
            end
         end

         assign done_mask[gi] = done_acc_reg;
         assign pass_mask[gi] = pass_acc_reg;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         busy_reg      <= 1'b0;
         eoc_reg       <= 1'b0;
         eoc_pulse_reg <= 1'b0;
         timeout_reg   <= 1'b0;
         exit_code_reg <= 8'hFF;
         count_reg     <= '0;
      end else if (bus.clear_i) begin
         state_reg     <= IDLE;
         busy_reg      <= 1'b0;
         eoc_reg       <= 1'b0;
         eoc_pulse_reg <= 1'b0;
         timeout_reg   <= 1'b0;
         exit_code_reg <= 8'hFF;
         count_reg     <= '0;
      end else if (arm) begin
         state_reg     <= RUN;
         busy_reg      <= 1'b1;
         eoc_reg       <= 1'b0;
         eoc_pulse_reg <= 1'b0;
         timeout_reg   <= 1'b0;
         exit_code_reg <= 8'hFF;
         count_reg     <= '0;
      end else if (go_done) begin
         state_reg     <= DONE;
         busy_reg      <= 1'b0;
         eoc_reg       <= 1'b1;
         eoc_pulse_reg <= 1'b1;
         exit_code_reg <= (&pass_mask) ? 8'h00 : 8'h01;
      end else if (go_timeout) begin
         state_reg     <= TIMEOUT;
         busy_reg      <= 1'b0;
         eoc_reg       <= 1'b1;
         eoc_pulse_reg <= 1'b1;
         timeout_reg   <= 1'b1;
         exit_code_reg <= 8'hFF;
      end else begin
         eoc_pulse_reg <= 1'b0;
         // Saturate rather than wrap so a runaway run never looks short.
         if (run_hold && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
         end
      end
   end

   assign bus.busy_o        = busy_reg;
   assign bus.eoc_o         = eoc_reg;
   assign bus.eoc_pulse_o   = eoc_pulse_reg;
   assign bus.timeout_o     = timeout_reg;
   assign bus.exit_code_o   = exit_code_reg;
   assign bus.done_mask_o   = done_mask;
   assign bus.pass_mask_o   = pass_mask;
   assign bus.cycle_count_o = count_reg;
endmodule

// File: tb/tb_eoc_monitor.sv
// Directed plus randomized bench for eoc_monitor; a rule-based reference model built on
// input sample histories predicts every output after each clock edge.
module tb_eoc_monitor;
   localparam int NC = 2;
   localparam int S  = 4;
   localparam int TW = 32;
   localparam int HN = 32768;
   localparam logic [TW-1:0] CMAX = '1;

   typedef enum int {M_IDLE, M_RUN, M_DONE, M_TIMEOUT} mstate_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   eoc_monitor_if #(.NUM_CH(NC), .TIMEOUT_W(TW)) bus ();

   eoc_monitor #(.NUM_CH(NC), .STABLE_CYCLES(S), .TIMEOUT_W(TW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors     = 0;
   int miscompares = 0;
   int n           = 0;
   int floor_n     = 0;

   logic          hstart [HN];
   logic [NC-1:0] hdone  [HN];
   logic [NC-1:0] hpass  [HN];

   mstate_t       m_state;
   logic [TW-1:0] m_count;
   logic [NC-1:0] m_done;
   logic [NC-1:0] m_pass;
   logic [7:0]    m_exit;
   logic          m_pulse;
   int            m_entry;

   // Samples taken before the first post-reset edge read as the flop reset values.
   function automatic logic h_start(int k);
      if (k < floor_n) return 1'b1;
      return hstart[k];
   endfunction

   function automatic logic h_done(int k, int c);
      if (k < floor_n) return 1'b0;
      return hdone[k][c];
   endfunction

   function automatic logic h_pass(int k, int c);
      if (k < floor_n) return 1'b0;
      return hpass[k][c];
   endfunction

   task automatic model_reset();
      m_state = M_IDLE;
      m_count = '0;
      m_done  = '0;
      m_pass  = '0;
      m_exit  = 8'hFF;
      m_pulse = 1'b0;
      m_entry = 0;
   endtask

   // Applies the block's rules to the inputs sampled at edge n.
   task automatic model_edge();
      mstate_t nxt;
      logic    sedge;
      logic    arm_m;
      logic    acc;
      bit      stay;
      nxt   = m_state;
      arm_m = 1'b0;
      sedge = h_start(n - 1) && !h_start(n - 2);
      if (bus.clear_i) nxt = M_IDLE;
      else if (sedge && m_state != M_RUN) begin
         nxt   = M_RUN;
         arm_m = 1'b1;
      end else if (m_state == M_RUN) begin
         if (m_done == '1) nxt = M_DONE;
         else if (bus.timeout_cycles_i != '0 && m_count >= bus.timeout_cycles_i) nxt = M_TIMEOUT;
      end
      stay    = (m_state == M_RUN) && (nxt == M_RUN);
      m_pulse = (nxt == M_DONE || nxt == M_TIMEOUT) && (nxt != m_state);
      if (bus.clear_i || arm_m) begin
         m_count = '0;
         m_done  = '0;
         m_pass  = '0;
         m_exit  = 8'hFF;
         if (arm_m) m_entry = n;
      end else if (stay) begin
         if (m_count != CMAX) m_count = m_count + 32'd1;
         // A channel is accepted once its last S synced samples inside this run are all high.
         for (int c = 0; c < NC; c++) begin
            if (!m_done[c] && (n - m_entry) >= S) begin
               acc = 1'b1;
               for (int k = 0; k < S; k++) if (!h_done(n - 2 - k, c)) acc = 1'b0;
               if (acc) begin
                  m_done[c] = 1'b1;
                  m_pass[c] = h_pass(n - 2, c);
               end
            end
         end
      end else if (nxt == M_DONE && m_state == M_RUN) begin
         m_exit = (m_pass == '1) ? 8'h00 : 8'h01;
      end else if (nxt == M_TIMEOUT && m_state == M_RUN) begin
         m_exit = 8'hFF;
      end
      m_state = nxt;
   endtask

   task automatic check_all(string tag);
      logic [47:0] obs;
      logic [47:0] exp;
      obs = {bus.busy_o, bus.eoc_o, bus.eoc_pulse_o, bus.timeout_o, bus.exit_code_o,
             bus.done_mask_o, bus.pass_mask_o, bus.cycle_count_o};
      exp = {m_state == M_RUN, m_state == M_DONE || m_state == M_TIMEOUT, m_pulse,
             m_state == M_TIMEOUT, m_exit, m_done, m_pass, m_count};
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s cycle %0d: observed %h expected %h", tag, n, obs, exp);
      end
   endtask

   task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s cycle %0d: observed %h expected %h", tag, n, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      n++;
      if (n >= HN) begin
         $display("FAIL history_overflow cycle %0d: observed %0d expected below %0d", n, n, HN);
         $fatal(1, "history overflow");
      end
      hstart[n] = bus.start_i;
      hdone[n]  = bus.done_i;
      hpass[n]  = bus.pass_i;
      if (rst) begin
         floor_n = n + 1;
         model_reset();
      end else begin
         model_edge();
      end
      #1;
      check_all("cycle");
   endtask

   task automatic arm();
      bus.start_i = 1'b0;
      step();
      step();
      bus.start_i = 1'b1;
      step();
      step();
   endtask

   task automatic clear_pulse();
      bus.clear_i = 1'b1;
      step();
      bus.clear_i = 1'b0;
      step();
   endtask

   task automatic wait_eoc(input int budget, input string tag, output int steps);
      steps = 0;
      while (!bus.eoc_o && steps < budget) begin
         step();
         steps++;
      end
      check_val({tag, "_eoc"}, 32'(bus.eoc_o), 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_watchdog cycle %0d: observed no finish expected finish", n);
      $fatal(1, "watchdog");
   end

   initial begin
      int steps;
      int t [NC];
      logic [NC-1:0] pbase;
      logic [NC-1:0] d;

      bus.start_i          = 1'b0;
      bus.clear_i          = 1'b0;
      bus.done_i           = '0;
      bus.pass_i           = '0;
      bus.timeout_cycles_i = 32'd1000;
      model_reset();

      // Reset values
      repeat (3) step();
      check_val("rst_busy", 32'(bus.busy_o), 32'd0);
      check_val("rst_exit", 32'(bus.exit_code_o), 32'h0000_00FF);
      check_val("rst_count", bus.cycle_count_o, 32'd0);
      rst = 1'b0;
      repeat (2) step();

      // All pass
      arm();
      check_val("t1_busy", 32'(bus.busy_o), 32'd1);
      bus.pass_i = 2'b11;
      bus.done_i = 2'b11;
      wait_eoc(40, "t1", steps);
      check_val("t1_latency", 32'(steps), 32'd7);
      check_val("t1_pulse", 32'(bus.eoc_pulse_o), 32'd1);
      check_val("t1_exit", 32'(bus.exit_code_o), 32'h0000_0000);
      check_val("t1_done_mask", 32'(bus.done_mask_o), 32'd3);
      step();
      check_val("t1_pulse_drop", 32'(bus.eoc_pulse_o), 32'd0);
      check_val("t1_eoc_level", 32'(bus.eoc_o), 32'd1);

      // One channel fails
      bus.done_i = 2'b00;
      bus.pass_i = 2'b01;
      arm();
      bus.done_i = 2'b11;
      wait_eoc(40, "t2", steps);
      check_val("t2_exit", 32'(bus.exit_code_o), 32'h0000_0001);
      check_val("t2_pass_mask", 32'(bus.pass_mask_o), 32'd1);

      // Glitch filtering
      bus.done_i = 2'b00;
      bus.pass_i = 2'b11;
      arm();
      bus.done_i = 2'b01;
      repeat (3) step();
      bus.done_i = 2'b00;
      repeat (6) step();
      check_val("t3_glitch_mask", 32'(bus.done_mask_o), 32'd0);
      bus.done_i = 2'b01;
      repeat (4) step();
      bus.done_i = 2'b00;
      repeat (3) step();
      check_val("t3_held_mask", 32'(bus.done_mask_o), 32'd1);
      bus.done_i = 2'b11;
      wait_eoc(40, "t3", steps);
      check_val("t3_exit", 32'(bus.exit_code_o), 32'h0000_0000);

      // Watchdog at limit 50
      bus.done_i           = 2'b00;
      bus.timeout_cycles_i = 32'd50;
      arm();
      wait_eoc(100, "t4", steps);
      check_val("t4_run_cycles", 32'(steps), 32'd51);
      check_val("t4_timeout", 32'(bus.timeout_o), 32'd1);
      check_val("t4_exit", 32'(bus.exit_code_o), 32'h0000_00FF);
      check_val("t4_count", bus.cycle_count_o, 32'd50);

      // Limit 0 disables the watchdog
      clear_pulse();
      check_val("t5_idle", 32'(bus.eoc_o), 32'd0);
      bus.timeout_cycles_i = 32'd0;
      arm();
      repeat (10000) step();
      check_val("t5_no_timeout", 32'(bus.timeout_o), 32'd0);
      check_val("t5_busy", 32'(bus.busy_o), 32'd1);

      // Final acceptance on the edge the count reaches the limit
      clear_pulse();
      bus.timeout_cycles_i = 32'd20;
      arm();
      repeat (14) step();
      bus.done_i = 2'b11;
      bus.pass_i = 2'b11;
      wait_eoc(40, "t6", steps);
      check_val("t6_latency", 32'(steps), 32'd7);
      check_val("t6_exit", 32'(bus.exit_code_o), 32'h0000_0000);
      check_val("t6_timeout", 32'(bus.timeout_o), 32'd0);
      check_val("t6_count", bus.cycle_count_o, 32'd20);

      // clear_i together with a start edge while in DONE
      bus.done_i  = 2'b00;
      bus.start_i = 1'b0;
      step();
      step();
      bus.start_i = 1'b1;
      step();
      bus.clear_i = 1'b1;
      step();
      bus.clear_i = 1'b0;
      repeat (3) step();
      check_val("t7_busy", 32'(bus.busy_o), 32'd0);
      check_val("t7_eoc", 32'(bus.eoc_o), 32'd0);
      check_val("t7_exit", 32'(bus.exit_code_o), 32'h0000_00FF);

      // Asynchronous reset mid-RUN with start_i held high
      bus.timeout_cycles_i = 32'd1000;
      arm();
      bus.done_i = 2'b01;
      steps = 0;
      while (bus.done_mask_o != 2'b01 && steps < 20) begin
         step();
         steps++;
      end
      check_val("t8_pre_mask", 32'(bus.done_mask_o), 32'd1);
      #2;
      rst = 1'b1;
      floor_n = n + 1;
      model_reset();
      #1;
      check_all("t8_async");
      check_val("t8_rst_mask", 32'(bus.done_mask_o), 32'd0);
      check_val("t8_rst_busy", 32'(bus.busy_o), 32'd0);
      check_val("t8_rst_exit", 32'(bus.exit_code_o), 32'h0000_00FF);
      repeat (2) step();
      rst = 1'b0;
      repeat (5) step();
      check_val("t8_stay_idle", 32'(bus.busy_o), 32'd0);
      arm();
      check_val("t8_rearm", 32'(bus.busy_o), 32'd1);

      // Randomized runs
      for (int it = 0; it < 25; it++) begin
         case ($urandom_range(0, 2))
            0:       bus.timeout_cycles_i = 32'd0;
            1:       bus.timeout_cycles_i = 32'($urandom_range(15, 60));
            default: bus.timeout_cycles_i = 32'd1000;
         endcase
         pbase = NC'($urandom);
         for (int c = 0; c < NC; c++) t[c] = $urandom_range(0, 60);
         bus.done_i = '0;
         if (bus.busy_o || $urandom_range(0, 1) == 1) clear_pulse();
         arm();
         for (int cyc = 0; cyc < 150 && !bus.eoc_o; cyc++) begin
            for (int c = 0; c < NC; c++) d[c] = (cyc >= t[c]) || ($urandom_range(0, 3) == 0);
            bus.done_i = d;
            bus.pass_i = ($urandom_range(0, 7) == 0) ? (pbase ^ NC'($urandom)) : pbase;
            step();
         end
         check_val("rnd_eoc", 32'(bus.eoc_o), 32'd1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/eoc_monitor.md
# eoc_monitor

Parametrised end-of-computation monitor for the PULPino simulation and FPGA bring-up flow. It replaces the hard-wired single-bit `gpio_out[8]` wait with a checked completion tracker. It watches up to NUM_CH done/pass flag pairs driven from GPIO, filters glitches, enforces a cycle-count watchdog, and produces a PULPino-style exit code (0 success, 1 fail, -1 error). It sits beside `pulpino_top` and is fed from `gpio_out`; its outputs drive the harness's pass/fail reporting or an FPGA status LED/register.

## Interface
- NUM_CH, 1, number of monitored done/pass channels (1..8)
- STABLE_CYCLES, 4, consecutive synchronised high samples required to accept a done flag (1..255)
- TIMEOUT_W, 32, width of watchdog limit and cycle counter

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  arm/run request (e.g. fetch_enable); rising edge detected internally
- clear_i  in  1  synchronous return to IDLE
- done_i  in  NUM_CH  per-channel done flag, asynchronous to clk
- pass_i  in  NUM_CH  per-channel pass flag, sampled when its done is accepted
- timeout_cycles_i  in  TIMEOUT_W  watchdog limit; 0 disables the watchdog
- busy_o  out  1  high in RUN
- eoc_o  out  1  level, high in DONE or TIMEOUT
- eoc_pulse_o  out  1  one-cycle pulse on entry to DONE or TIMEOUT
- timeout_o  out  1  high in TIMEOUT
- exit_code_o  out  8  signed: 8'h00 pass, 8'h01 fail, 8'hFF error/not finished
- done_mask_o  out  NUM_CH  accepted done flags (sticky)
- pass_mask_o  out  NUM_CH  pass value captured at each acceptance
- cycle_count_o  out  TIMEOUT_W  cycles spent in RUN, saturating

## Operation
- FSM states: IDLE, RUN, DONE, TIMEOUT.
- IDLE -> RUN: on a start_i rising edge. Entering RUN clears the cycle counter, the filter counters and both masks.
- RUN -> DONE: when done_mask is all ones. exit_code = 0 if pass_mask is all ones, else 1.
- RUN -> TIMEOUT: when timeout_cycles_i != 0 and cycle_count reaches timeout_cycles_i. exit_code = 8'hFF.
- DONE/TIMEOUT -> RUN: on a new start_i rising edge (re-arm; same clearing as entry).
- Any state -> IDLE: on clear_i. Masks, counter and exit code return to their reset values.
- Synchronisation and filtering: done_i and pass_i each pass through a 2-flop synchroniser. A per-channel filter counter increments on each cycle the synced done bit is high and resets to 0 on any low sample. When the count reaches STABLE_CYCLES, the done_mask bit sets and the synced pass bit is captured into pass_mask. The bit is then frozen until the next clear or start.
- Flags seen outside RUN are ignored (filters held at 0).
- Cycle counter: increments every RUN cycle and saturates at all-ones, so there is no wrap.
- Priorities, highest first: rst > clear_i > start edge > completion > timeout.
- If the final done acceptance and the timeout limit land on the same edge, the block enters DONE.
- start_i rising while in RUN is ignored.

## Timing
- Reset values: busy_o 0, eoc_o 0, eoc_pulse_o 0, timeout_o 0, exit_code_o 8'hFF, done_mask_o 0, pass_mask_o 0, cycle_count_o 0, state IDLE.
- start_i is sampled at edge E. busy_o is high after E+1, because edge detection needs one register stage.
- done_i is high and stable from before edge e0. The synced bit is valid after e0+1 and the mask bit sets at edge e0+1+STABLE_CYCLES. The state enters DONE at e0+2+STABLE_CYCLES, when eoc_pulse_o is high for exactly that one cycle.
- Timeout: state changes on the edge after the edge at which cycle_count equals timeout_cycles_i.
- Outputs are registered and decoded from state and registers only, with no combinational paths from inputs.
- Asserting rst mid-RUN clears everything immediately. After release, the block waits in IDLE for a fresh start edge, even if start_i is already high.

## Test plan
- NUM_CH=2, STABLE_CYCLES=4, limit 1000: start, then done_i=2'b11 with pass_i=2'b11 -> DONE, exit_code 8'h00, eoc_pulse_o one cycle, done_mask 2'b11.
- Same setup but pass_i=2'b01 -> exit_code 8'h01, pass_mask 2'b01.
- Channel 0 done glitch high for 3 cycles, then low -> done_mask stays 2'b00. Holding it for 4 cycles -> bit 0 sets.
- Limit 50, no done -> TIMEOUT at RUN cycle 51, timeout_o=1, exit_code 8'hFF, cycle_count_o=50. Limit 0 -> no timeout after 10000 cycles.
- Final acceptance on the same edge as the count reaches the limit -> DONE, exit_code 0, timeout_o 0. clear_i and a start edge together in DONE -> IDLE.
- rst pulsed mid-RUN with done_mask 2'b01 -> all outputs at reset values. start_i held high through reset -> stays IDLE until start_i toggles low then high.
